// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS Memory stage: word RAM with programmable wait states and pipeline stall.
// Optional byte-strobe stores are enabled with the DMEM_BYTE_WRITE_EN macro (adds the wr_strb port).
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_readM,
    input  logic        mem_writeM,
    input  logic [31:0] addrM,
    input  logic [31:0] write_dataM,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]  wr_strb,
`endif
    output logic [31:0] read_dataM,
    output logic        stall_mem,
    output logic        misalign_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       rdata_q;

    logic [3:0][7:0]   mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic              req;
    logic              aligned;
    logic              busy_fire;
    logic              ram_we;
    logic              ram_re;
    logic              rdata_clr;
    logic [3:0]        byte_en;

    assign word_idx  = addrM[ADDR_W+1:2];
    assign req       = mem_readM | mem_writeM;
    assign aligned   = (addrM[1:0] == 2'b00);
    assign busy_fire = (state_q == S_BUSY) && (cnt_q == 4'd0);

    // rst is folded in so an access aborted by reset can never reach the RAM.
    assign ram_we    = busy_fire && mem_writeM && rst;
    assign ram_re    = busy_fire && mem_readM;
    assign rdata_clr = (state_q == S_IDLE) && req && !aligned;

`ifdef DMEM_BYTE_WRITE_EN
    assign byte_en = wr_strb;
`else
    assign byte_en = 4'hF;
`endif

    // Bits above the RAM window are deliberately ignored so addresses wrap.
    generate
        if (ADDR_W + 2 < 32) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^addrM[31:ADDR_W+2];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;
        case (state_q)
            S_IDLE: begin
                if (req && aligned) begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_BUSY;
                end else if (req) begin
                    misalign_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            misalign_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            // A combined read+write sees the pre-write word: this read uses the old array value.
            if (ram_re) begin
                rdata_q <= mem[word_idx];
            end else if (rdata_clr) begin
                rdata_q <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b] <= write_dataM[b*8 +: 8];
                end
            end
        end
    end

    assign stall_mem    = rst && (((state_q == S_IDLE) && req && aligned) || (state_q == S_BUSY));
    assign read_dataM   = rdata_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at the default WAIT_CYCLES=2, DEPTH_WORDS=1024.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_readM = 1'b0;
    logic        mem_writeM = 1'b0;
    logic [31:0] addrM = 32'd0;
    logic [31:0] write_dataM = 32'd0;
    logic [3:0]  wr_strb = 4'hF;
    logic [31:0] read_dataM;
    logic        stall_mem;
    logic        misalign_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_readM   (mem_readM),
        .mem_writeM  (mem_writeM),
        .addrM       (addrM),
        .write_dataM (write_dataM),
`ifdef DMEM_BYTE_WRITE_EN
        .wr_strb     (wr_strb),
`endif
        .read_dataM  (read_dataM),
        .stall_mem   (stall_mem),
        .misalign_err(misalign_err)
    );

    // Called at a falling edge with the DUT in IDLE; cycle 0 is the cycle the request is first driven.
    // Returns the stall-high cycle count, the DONE cycle number (-1 on timeout) and read_dataM in DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             output int stalls, output int done_cyc, output logic [31:0] rdata);
        stalls = 0;
        done_cyc = -1;
        rdata = 32'hxxxxxxxx;
        mem_readM = rd;
        mem_writeM = wr;
        addrM = a;
        write_dataM = d;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c >= 1 && !stall_mem) begin
                done_cyc = c;
                rdata = read_dataM;
                break;
            end
            if (stall_mem) stalls++;
            @(negedge clk);
        end
        mem_readM = 1'b0;
        mem_writeM = 1'b0;
        @(negedge clk);
        $display("access rd=%0b wr=%0b addr=%h wdata=%h -> stalls=%0d done=%0d rdata=%h",
                 rd, wr, a, d, stalls, done_cyc, rdata);
    endtask

    task automatic test_reset();
        mem_readM = 1'b1;
        addrM = 32'h10;
        repeat (3) @(negedge clk);
        #1;
        total++; if (read_dataM !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", read_dataM, 32'd0); end
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_mem); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b want=0", misalign_err); end
        @(negedge clk);
        mem_readM = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", stall_mem); end
        @(negedge clk);
        $display("reset test done");
    endtask

    task automatic test_store_load();
        int s, dc;
        logic [31:0] r;
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, s, dc, r);
        total++; if (s !== 4) begin bad++; $display("FAIL store_stalls got=%0d want=4", s); end
        total++; if (dc !== 4) begin bad++; $display("FAIL store_done got=%0d want=4", dc); end
        do_access(1'b1, 1'b0, 32'h10, 32'h0, s, dc, r);
        total++; if (s !== 4) begin bad++; $display("FAIL load_stalls got=%0d want=4", s); end
        total++; if (dc !== 4) begin bad++; $display("FAIL load_done got=%0d want=4", dc); end
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", r); end
    endtask

    task automatic test_misalign();
        int s, dc;
        logic [31:0] r;
        do_access(1'b1, 1'b0, 32'h13, 32'h0, s, dc, r);
        total++; if (s !== 0) begin bad++; $display("FAIL mis_stalls got=%0d want=0", s); end
        total++; if (dc !== 1) begin bad++; $display("FAIL mis_done got=%0d want=1", dc); end
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mis_rdata got=%h want=0", r); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", misalign_err); end
        // A misaligned store must not touch RAM either.
        do_access(1'b0, 1'b1, 32'h12, 32'h12345678, s, dc, r);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, s, dc, r);
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL mis_ram_intact got=%h want=deadbeef", r); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b want=1", misalign_err); end
    endtask

    task automatic test_read_write_same();
        int s, dc;
        logic [31:0] r;
        do_access(1'b0, 1'b1, 32'h20, 32'h11111111, s, dc, r);
        do_access(1'b1, 1'b1, 32'h20, 32'h22222222, s, dc, r);
        total++; if (r !== 32'h11111111) begin bad++; $display("FAIL rw_old got=%h want=11111111", r); end
        total++; if (dc !== 4) begin bad++; $display("FAIL rw_done got=%0d want=4", dc); end
        do_access(1'b1, 1'b0, 32'h20, 32'h0, s, dc, r);
        total++; if (r !== 32'h22222222) begin bad++; $display("FAIL rw_new got=%h want=22222222", r); end
    endtask

    task automatic test_wrap();
        int s, dc;
        logic [31:0] r;
        do_access(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, s, dc, r);
        do_access(1'b1, 1'b0, 32'h0, 32'h0, s, dc, r);
        total++; if (r !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap got=%h want=cafef00d", r); end
    endtask

    task automatic test_reset_busy();
        int s, dc;
        logic [31:0] r;
        do_access(1'b0, 1'b1, 32'h40, 32'h0, s, dc, r);
        mem_writeM = 1'b1;
        addrM = 32'h40;
        write_dataM = 32'h55555555;
        #1;
        total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL rb_stall0 got=%b want=1", stall_mem); end
        @(negedge clk);
        #1;
        total++; if (stall_mem !== 1'b1) begin bad++; $display("FAIL rb_stall1 got=%b want=1", stall_mem); end
        rst = 1'b0;
        #1;
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL rb_stall_async got=%b want=0", stall_mem); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rb_misalign got=%b want=0", misalign_err); end
        total++; if (read_dataM !== 32'd0) begin bad++; $display("FAIL rb_rdata got=%h want=0", read_dataM); end
        repeat (2) @(negedge clk);
        mem_writeM = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, s, dc, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rb_no_write got=%h want=0", r); end
    endtask

    task automatic test_back_to_back();
        int s1, d1, s2, d2;
        logic [31:0] r1, r2;
        do_access(1'b1, 1'b0, 32'h20, 32'h0, s1, d1, r1);
        do_access(1'b1, 1'b0, 32'h1010, 32'h0, s2, d2, r2);
        total++; if (r1 !== 32'h22222222) begin bad++; $display("FAIL b2b_first got=%h want=22222222", r1); end
        total++; if (r2 !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_second got=%h want=deadbeef", r2); end
        total++; if (d2 !== 4 || s2 !== 4) begin bad++; $display("FAIL b2b_timing got=done%0d/stall%0d want=4/4", d2, s2); end
    endtask

`ifdef DMEM_BYTE_WRITE_EN
    task automatic test_byte_write();
        int s, dc;
        logic [31:0] r;
        wr_strb = 4'hF;
        do_access(1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, s, dc, r);
        wr_strb = 4'b0011;
        do_access(1'b0, 1'b1, 32'h80, 32'h0000ABCD, s, dc, r);
        wr_strb = 4'hF;
        do_access(1'b1, 1'b0, 32'h80, 32'h0, s, dc, r);
        total++; if (r !== 32'hFFFFABCD) begin bad++; $display("FAIL byte_write got=%h want=ffffabcd", r); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_store_load();
        test_misalign();
        test_read_write_same();
        test_wrap();
        test_back_to_back();
        test_reset_busy();
`ifdef DMEM_BYTE_WRITE_EN
        test_byte_write();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
